// File: rtl/execute_stage.sv
// execute_stage: DLX EX stage (ALU, branch/jump resolution, EX/MEM register).
// Define EXEC_MULDIV_EN to build the iterative unsigned MUL/DIVU unit with its stall FSM.
module execute_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int PC_WIDTH        = 20,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FUNCTION_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int PC_OFFSET_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      data_alu_a_in,
  input  logic [DATA_WIDTH-1:0]      data_alu_b_in,
  input  logic [DATA_WIDTH-1:0]      constant_in,
  input  logic                       imm_inst_in,
  input  logic [PC_WIDTH-1:0]        new_pc_in,
  input  logic [OPCODE_WIDTH-1:0]    opcode_in,
  input  logic [FUNCTION_WIDTH-1:0]  inst_function_in,
  input  logic [PC_OFFSET_WIDTH-1:0] pc_offset_in,
  input  logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_in,
  input  logic                       reg_wr_en_in,
  input  logic                       mem_data_rd_en_in,
  input  logic                       mem_data_wr_en_in,
  input  logic                       write_back_mux_sel_in,
  input  logic                       branch_inst_in,
  input  logic                       jump_inst_in,
  input  logic                       jump_use_r_in,
  output logic                       stall_out,
  output logic [DATA_WIDTH-1:0]      alu_result_out,
  output logic [DATA_WIDTH-1:0]      store_data_out,
  output logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_out,
  output logic                       reg_wr_en_out,
  output logic                       mem_data_rd_en_out,
  output logic                       mem_data_wr_en_out,
  output logic                       write_back_mux_sel_out,
  output logic                       branch_taken_out,
  output logic [PC_WIDTH-1:0]        branch_target_out
);
  localparam logic [OPCODE_WIDTH-1:0]   OP_BEQZ = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0]   OP_BNEZ = OPCODE_WIDTH'(5);
  localparam logic [FUNCTION_WIDTH-1:0] F_ADD  = FUNCTION_WIDTH'(5'h00);
  localparam logic [FUNCTION_WIDTH-1:0] F_SUB  = FUNCTION_WIDTH'(5'h01);
  localparam logic [FUNCTION_WIDTH-1:0] F_AND  = FUNCTION_WIDTH'(5'h02);
  localparam logic [FUNCTION_WIDTH-1:0] F_OR   = FUNCTION_WIDTH'(5'h03);
  localparam logic [FUNCTION_WIDTH-1:0] F_XOR  = FUNCTION_WIDTH'(5'h04);
  localparam logic [FUNCTION_WIDTH-1:0] F_SLL  = FUNCTION_WIDTH'(5'h05);
  localparam logic [FUNCTION_WIDTH-1:0] F_SRL  = FUNCTION_WIDTH'(5'h06);
  localparam logic [FUNCTION_WIDTH-1:0] F_SRA  = FUNCTION_WIDTH'(5'h07);
  localparam logic [FUNCTION_WIDTH-1:0] F_SLT  = FUNCTION_WIDTH'(5'h08);
  localparam logic [FUNCTION_WIDTH-1:0] F_MUL  = FUNCTION_WIDTH'(5'h10);
  localparam logic [FUNCTION_WIDTH-1:0] F_DIVU = FUNCTION_WIDTH'(5'h11);

  logic [DATA_WIDTH-1:0] w_b, w_alu, w_md_result, w_result;
  logic [PC_WIDTH-1:0]   w_target;
  logic                  w_taken, w_stall;

  assign w_b = imm_inst_in ? constant_in : data_alu_b_in;

  always_comb begin
    w_alu = '0;
    case (inst_function_in)
      F_ADD:        w_alu = data_alu_a_in + w_b;
      F_SUB:        w_alu = data_alu_a_in - w_b;
      F_AND:        w_alu = data_alu_a_in & w_b;
      F_OR:         w_alu = data_alu_a_in | w_b;
      F_XOR:        w_alu = data_alu_a_in ^ w_b;
      F_SLL:        w_alu = data_alu_a_in << w_b[4:0];
      F_SRL:        w_alu = data_alu_a_in >> w_b[4:0];
      F_SRA:        w_alu = $signed(data_alu_a_in) >>> w_b[4:0];
      F_SLT:        w_alu = DATA_WIDTH'($signed(data_alu_a_in) < $signed(w_b));
      F_MUL, F_DIVU: w_alu = w_md_result;
      default:      w_alu = '0;
    endcase
  end

  assign w_taken  = jump_inst_in || (branch_inst_in &&
                    ((opcode_in == OP_BEQZ && data_alu_a_in == '0) ||
                     (opcode_in == OP_BNEZ && data_alu_a_in != '0)));
  assign w_target = !jump_inst_in ? new_pc_in + PC_WIDTH'(constant_in) :
                    jump_use_r_in ? PC_WIDTH'(data_alu_a_in) : new_pc_in + PC_WIDTH'(pc_offset_in);
  assign w_result = jump_inst_in ? DATA_WIDTH'(new_pc_in) : w_alu;
  assign stall_out = w_stall;

`ifdef EXEC_MULDIV_EN
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_op_a, r_op_b, r_acc, w_mul_acc;
  logic [DATA_WIDTH:0]   w_rem_sh, w_diff;
  logic                  r_is_div, w_md_op, w_start, w_last, w_div_ok;

  // r_op_a: multiplier / dividend-becoming-quotient; r_op_b: multiplicand / divisor; r_acc: product / remainder
  assign w_md_op   = inst_function_in == F_MUL || inst_function_in == F_DIVU;
  assign w_start   = r_state == S_IDLE && w_md_op;
  assign w_last    = r_state == S_BUSY && r_cnt == CW'(DATA_WIDTH - 1);
  assign w_rem_sh  = {r_acc, r_op_a[DATA_WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_op_b};
  assign w_div_ok  = !w_diff[DATA_WIDTH];
  assign w_mul_acc = r_acc + (r_op_a[0] ? r_op_b : '0);
  assign w_md_result = !r_is_div ? w_mul_acc :
                       r_op_b == '0 ? '1 : {r_op_a[DATA_WIDTH-2:0], w_div_ok};
  assign w_stall   = w_start || (r_state == S_BUSY && !w_last);

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_start ? S_BUSY : w_last ? S_IDLE : r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt    <= '0;
        r_op_a   <= data_alu_a_in;
        r_op_b   <= w_b;
        r_acc    <= '0;
        r_is_div <= inst_function_in == F_DIVU;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_acc  <= w_div_ok ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
          r_op_a <= {r_op_a[DATA_WIDTH-2:0], w_div_ok};
        end else begin
          r_acc  <= w_mul_acc;
          r_op_a <= r_op_a >> 1;
          r_op_b <= r_op_b << 1;
        end
      end
    end
  end
`else
  assign w_md_result = '0;
  assign w_stall     = 1'b0;
`endif

  // a stalled cycle pushes an all-zero bubble into EX/MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out         <= '0;
      store_data_out         <= '0;
      reg_wr_addr_out        <= '0;
      reg_wr_en_out          <= 1'b0;
      mem_data_rd_en_out     <= 1'b0;
      mem_data_wr_en_out     <= 1'b0;
      write_back_mux_sel_out <= 1'b0;
      branch_taken_out       <= 1'b0;
      branch_target_out      <= '0;
    end else begin
      alu_result_out         <= w_stall ? '0 : w_result;
      store_data_out         <= w_stall ? '0 : data_alu_b_in;
      reg_wr_addr_out        <= w_stall ? '0 : reg_wr_addr_in;
      reg_wr_en_out          <= !w_stall && reg_wr_en_in;
      mem_data_rd_en_out     <= !w_stall && mem_data_rd_en_in;
      mem_data_wr_en_out     <= !w_stall && mem_data_wr_en_in;
      write_back_mux_sel_out <= !w_stall && write_back_mux_sel_in;
      branch_taken_out       <= !w_stall && w_taken;
      branch_target_out      <= w_stall ? '0 : w_target;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table-driven self-checking bench for execute_stage with a scoreboard queue.
// Multi-cycle MUL/DIVU sequences run when EXEC_MULDIV_EN is defined; otherwise the disabled-unit behaviour is checked.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_alu_a_in, data_alu_b_in, constant_in;
  logic        imm_inst_in;
  logic [19:0] new_pc_in;
  logic [5:0]  opcode_in;
  logic [4:0]  inst_function_in;
  logic [25:0] pc_offset_in;
  logic [4:0]  reg_wr_addr_in;
  logic        reg_wr_en_in, mem_data_rd_en_in, mem_data_wr_en_in, write_back_mux_sel_in;
  logic        branch_inst_in, jump_inst_in, jump_use_r_in;
  logic        stall_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  reg_wr_addr_out;
  logic        reg_wr_en_out, mem_data_rd_en_out, mem_data_wr_en_out, write_back_mux_sel_out;
  logic        branch_taken_out;
  logic [19:0] branch_target_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .data_alu_a_in(data_alu_a_in), .data_alu_b_in(data_alu_b_in), .constant_in(constant_in),
    .imm_inst_in(imm_inst_in), .new_pc_in(new_pc_in), .opcode_in(opcode_in),
    .inst_function_in(inst_function_in), .pc_offset_in(pc_offset_in),
    .reg_wr_addr_in(reg_wr_addr_in), .reg_wr_en_in(reg_wr_en_in),
    .mem_data_rd_en_in(mem_data_rd_en_in), .mem_data_wr_en_in(mem_data_wr_en_in),
    .write_back_mux_sel_in(write_back_mux_sel_in),
    .branch_inst_in(branch_inst_in), .jump_inst_in(jump_inst_in), .jump_use_r_in(jump_use_r_in),
    .stall_out(stall_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .reg_wr_addr_out(reg_wr_addr_out), .reg_wr_en_out(reg_wr_en_out),
    .mem_data_rd_en_out(mem_data_rd_en_out), .mem_data_wr_en_out(mem_data_wr_en_out),
    .write_back_mux_sel_out(write_back_mux_sel_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
  );

  typedef struct {
    logic [4:0]  fn;
    logic [31:0] a, b, c;
    logic        imm;
    logic [5:0]  op;
    logic        br, j, ur;
    logic [19:0] pc;
    logic [25:0] off;
    logic [31:0] e_alu;
    logic        e_tk;
    logic [19:0] e_tgt;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] alu, st;
    logic [4:0]  addr;
    logic [3:0]  ctl;
    logic        tk;
    logic [19:0] tgt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mkv(logic [4:0] fn, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                               logic imm, logic [5:0] op, logic br, logic j, logic ur,
                               logic [19:0] pc, logic [25:0] off, logic [31:0] e_alu,
                               logic e_tk, logic [19:0] e_tgt);
    vec_t v;
    v.fn = fn; v.a = a; v.b = b; v.c = c; v.imm = imm; v.op = op;
    v.br = br; v.j = j; v.ur = ur; v.pc = pc; v.off = off;
    v.e_alu = e_alu; v.e_tk = e_tk; v.e_tgt = e_tgt;
    return v;
  endfunction

  function automatic vec_t alu_v(logic [4:0] fn, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    return mkv(fn, a, b, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 20'h0, 26'h0, e, 1'b0, 20'h0);
  endfunction

  function automatic logic [3:0] ctl_of(int id);
    return 4'(id) ^ 4'h9;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int id);
    logic [3:0] ctl;
    ctl = ctl_of(id);
    inst_function_in = v.fn; data_alu_a_in = v.a; data_alu_b_in = v.b; constant_in = v.c;
    imm_inst_in = v.imm; opcode_in = v.op; branch_inst_in = v.br; jump_inst_in = v.j;
    jump_use_r_in = v.ur; new_pc_in = v.pc; pc_offset_in = v.off;
    reg_wr_addr_in = 5'(id + 1);
    {write_back_mux_sel_in, mem_data_wr_en_in, mem_data_rd_en_in, reg_wr_en_in} = ctl;
  endtask

  task automatic expect_v(input vec_t v, input int id);
    exp_t e;
    e.id = id; e.alu = v.e_alu; e.st = v.b; e.addr = 5'(id + 1);
    e.ctl = ctl_of(id); e.tk = v.e_tk; e.tgt = v.e_tgt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty, got alu %0h expected an entry", alu_result_out);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d alu", e.id), alu_result_out, e.alu);
    chk($sformatf("v%0d store", e.id), store_data_out, e.st);
    chk($sformatf("v%0d wr_addr", e.id), reg_wr_addr_out, e.addr);
    chk($sformatf("v%0d ctl", e.id),
        {write_back_mux_sel_out, mem_data_wr_en_out, mem_data_rd_en_out, reg_wr_en_out}, e.ctl);
    chk($sformatf("v%0d taken", e.id), branch_taken_out, e.tk);
    if (e.tk) chk($sformatf("v%0d target", e.id), branch_target_out, e.tgt);
  endtask

  task automatic run_single(input vec_t v, input int id);
    drive(v, id);
    expect_v(v, id);
    #1;
    chk($sformatf("v%0d stall", id), stall_out, 1'b0);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic run_md(input int id, input logic [4:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    int cycles, bad;
    v = alu_v(fn, a, b, e);
    drive(v, id);
    #1;
    cycles = 0;
    bad = 0;
    while (stall_out && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
      if (reg_wr_en_out || mem_data_rd_en_out || mem_data_wr_en_out || branch_taken_out) bad++;
    end
    chk($sformatf("md%0d stall cycles", id), cycles, 32);
    chk($sformatf("md%0d bubbles", id), bad, 0);
    expect_v(v, id);
    @(posedge clk); #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(alu_v(5'h00, 32'h0, 32'h0, 32'h0), 9);
    reg_wr_addr_in = 5'h0;
    reg_wr_en_in = 1'b0; mem_data_rd_en_in = 1'b0; mem_data_wr_en_in = 1'b0; write_back_mux_sel_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset alu", alu_result_out, 32'h0);
    chk("reset store", store_data_out, 32'h0);
    chk("reset wr_addr", reg_wr_addr_out, 5'h0);
    chk("reset ctl", {write_back_mux_sel_out, mem_data_wr_en_out, mem_data_rd_en_out, reg_wr_en_out}, 4'h0);
    chk("reset taken", branch_taken_out, 1'b0);
    chk("reset target", branch_target_out, 20'h0);
    chk("reset stall", stall_out, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(alu_v(5'h00, 32'd5, 32'd7, 32'd12));
    tbl.push_back(mkv(5'h01, 32'd3, 32'h55, 32'd5, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 20'h0, 26'h0,
                      32'hFFFF_FFFE, 1'b0, 20'h0));
    tbl.push_back(alu_v(5'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0));
    tbl.push_back(alu_v(5'h03, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0));
    tbl.push_back(alu_v(5'h04, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F));
    tbl.push_back(alu_v(5'h05, 32'h1, 32'd31, 32'h8000_0000));
    tbl.push_back(alu_v(5'h05, 32'h1, 32'h23, 32'h8));
    tbl.push_back(alu_v(5'h06, 32'h8000_0000, 32'd4, 32'h0800_0000));
    tbl.push_back(alu_v(5'h07, 32'h8000_0000, 32'd4, 32'hF800_0000));
    tbl.push_back(alu_v(5'h08, 32'hFFFF_FFFF, 32'h1, 32'h1));
    tbl.push_back(alu_v(5'h08, 32'h1, 32'hFFFF_FFFF, 32'h0));
    tbl.push_back(alu_v(5'h00, 32'hFFFF_FFFF, 32'h2, 32'h1));
    tbl.push_back(alu_v(5'h1F, 32'h1234, 32'h5678, 32'h0));
    tbl.push_back(mkv(5'h00, 32'h0, 32'h0, 32'h20, 1'b0, 6'h04, 1'b1, 1'b0, 1'b0, 20'h00100, 26'h0,
                      32'h0, 1'b1, 20'h00120));
    tbl.push_back(mkv(5'h00, 32'h0, 32'h0, 32'h20, 1'b0, 6'h05, 1'b1, 1'b0, 1'b0, 20'h00100, 26'h0,
                      32'h0, 1'b0, 20'h0));
    tbl.push_back(mkv(5'h00, 32'h5, 32'h0, 32'hFFFF_FFF0, 1'b0, 6'h05, 1'b1, 1'b0, 1'b0, 20'h00100, 26'h0,
                      32'h5, 1'b1, 20'h000F0));
    tbl.push_back(mkv(5'h00, 32'h5, 32'h0, 32'h20, 1'b0, 6'h04, 1'b1, 1'b0, 1'b0, 20'h00100, 26'h0,
                      32'h5, 1'b0, 20'h0));
    tbl.push_back(mkv(5'h00, 32'h0, 32'h0, 32'h30, 1'b0, 6'h04, 1'b1, 1'b0, 1'b0, 20'hFFFF0, 26'h0,
                      32'h0, 1'b1, 20'h00020));
    tbl.push_back(mkv(5'h00, 32'h0, 32'h0, 32'h20, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0, 20'h00100, 26'h0,
                      32'h0, 1'b0, 20'h0));
    tbl.push_back(mkv(5'h00, 32'hABC1_2345, 32'h0, 32'h0, 1'b0, 6'h12, 1'b0, 1'b1, 1'b1, 20'h00200, 26'h0,
                      32'h0000_0200, 1'b1, 20'h12345));
    tbl.push_back(mkv(5'h00, 32'h7, 32'h0, 32'h0, 1'b0, 6'h02, 1'b0, 1'b1, 1'b0, 20'hFFFF0, 26'h3F0_0020,
                      32'h000F_FFF0, 1'b1, 20'h00010));
`ifndef EXEC_MULDIV_EN
    tbl.push_back(alu_v(5'h10, 32'd6, 32'd7, 32'h0));
    tbl.push_back(alu_v(5'h11, 32'd9, 32'd3, 32'h0));
`endif
    for (int i = 0; i < tbl.size(); i++) run_single(tbl[i], i);

`ifdef EXEC_MULDIV_EN
    run_md(100, 5'h10, 32'h0001_0000, 32'h30, 32'h0030_0000);
    run_md(102, 5'h11, 32'd100, 32'd7, 32'd14);
    run_md(104, 5'h11, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_md(106, 5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_md(108, 5'h11, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    drive(alu_v(5'h10, 32'd3, 32'd4, 32'd12), 110);
    #1;
    chk("abort stall start", stall_out, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    drive(alu_v(5'h00, 32'h0, 32'h0, 32'h0), 111);
    rst_n = 1'b0;
    #1;
    chk("abort stall", stall_out, 1'b0);
    chk("abort alu", alu_result_out, 32'h0);
    chk("abort wr_en", reg_wr_en_out, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_single(alu_v(5'h00, 32'd2, 32'd3, 32'd5), 112);
    run_md(114, 5'h10, 32'd3, 32'd4, 32'd12);
`endif

    run_single(alu_v(5'h00, 32'd2, 32'd3, 32'd5), 120);
    rst_n = 1'b0;
    #1;
    chk("async reset alu", alu_result_out, 32'h0);
    chk("async reset wr_en", reg_wr_en_out, 1'b0);
    chk("async reset wr_addr", reg_wr_addr_out, 5'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
